// File: rtl/uart_pkg.sv
// UART shared definitions: RX framing state encoding, RX config floor and the
// register map that uart_core decodes.
// No ports; imported by uart_rx_frame and uart_core.
package uart_pkg;

  // Receive framing states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Smallest clks-per-bit the receiver accepts; below this it never leaves IDLE.
  localparam int MIN_CPB_DEFAULT = 4;

  // Register byte offsets decoded by uart_core.
  localparam logic [7:0] UART_REG_DATA   = 8'h00;
  localparam logic [7:0] UART_REG_STATUS = 8'h04;
  localparam logic [7:0] UART_REG_CTRL   = 8'h08;
  localparam logic [7:0] UART_REG_BAUD   = 8'h0C;

endpackage

// File: rtl/uart_rx_sync.sv
// RX line conditioner: 2-flop synchroniser, 3-sample majority vote and
// falling-edge detect. Ports: clk_i/rst_i, rx_i (async line), rx_s (synced line),
// maj (2-of-3 of the last three rx_s samples), fall (rx_s just went 1->0).
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s,
  output logic maj,
  output logic fall
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  // All flops preset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      hist_q <= {hist_q[1:0], rx_s};
    end
  end

  assign rx_s = sync_q[1];
  assign maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign fall = hist_q[0] & ~rx_s;

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: turns rx_i into bytes with parity/framing/break flags.
// Ports: clk_i/rst_i, rx_i line, en_i, clks_per_bit_i/parity_en_i/parity_odd_i config;
// rx_data_o/parity_err_o/frame_err_o held per frame, rx_valid_o/break_o pulses, busy_o.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int MIN_CPB   = MIN_CPB_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 en_i,
  input  logic [15:0]          clks_per_bit_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 busy_o
);

  localparam int IDX_W = $clog2(DATA_BITS + 3);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS);

  rx_state_e            state_q, state_d;
  logic [15:0]          cnt_q, cnt_d, n_q, n_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_d;
  logic                 par_en_q, par_en_d, par_odd_q, par_odd_d, par_bit_q, par_bit_d;
  logic                 valid_d, perr_d, ferr_d, brk_d;
  logic                 rx_s, maj, fall, mid, at_end;

  uart_rx_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx_i  (rx_i),
    .rx_s  (rx_s),
    .maj   (maj),
    .fall  (fall)
  );

  // Decision point sits just past mid-bit to cover the synchroniser/vote delay.
  assign mid    = (cnt_q == (n_q >> 1) + 16'd1);
  assign at_end = (cnt_q == n_q - 16'd1);
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = at_end ? 16'd0 : cnt_q + 16'd1;
    n_d       = n_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    par_bit_d = par_bit_q;
    valid_d   = 1'b0;
    brk_d     = 1'b0;
    data_d    = rx_data_o;
    perr_d    = parity_err_o;
    ferr_d    = frame_err_o;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (en_i && clks_per_bit_i >= 16'(MIN_CPB) && fall) begin
          state_d   = START;
          n_d       = clks_per_bit_i;
          par_en_d  = parity_en_i;
          par_odd_d = parity_odd_i;
          par_bit_d = 1'b0;
          idx_d     = '0;
        end
      end
      START: begin
        if (mid && maj) begin
          state_d = IDLE;          // line back high at mid-start: glitch
        end else if (at_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (mid) begin
          shreg_d = {maj, shreg_q[DATA_BITS-1:1]};  // LSB arrives first
          idx_d   = idx_q + 1'b1;
        end
        if (at_end && idx_q == LAST_IDX) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (mid) begin
          par_bit_d = maj;
        end
        if (at_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (mid) begin
          valid_d = 1'b1;
          data_d  = shreg_q;
          perr_d  = par_en_q && ((^shreg_q ^ par_bit_q) != par_odd_q);
          ferr_d  = ~maj;
          brk_d   = ~maj && (shreg_q == '0) && ~par_bit_q;
          // Good stop returns straight to IDLE so a back-to-back start is caught.
          state_d = maj ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        cnt_d = 16'd0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything, including a same-cycle stop decision.
    if (!en_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      brk_d   = 1'b0;
      data_d  = rx_data_o;
      perr_d  = parity_err_o;
      ferr_d  = frame_err_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      rx_valid_o   <= 1'b0;
      break_o      <= 1'b0;
      rx_data_o    <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      par_bit_q    <= par_bit_d;
      rx_valid_o   <= valid_d;
      break_o      <= brk_d;
      rx_data_o    <= data_d;
      parity_err_o <= perr_d;
      frame_err_o  <= ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

  logic        clk_i = 1'b0;
  logic        rst_i, rx_i, en_i, parity_en_i, parity_odd_i;
  logic [15:0] clks_per_bit_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, parity_err_o, frame_err_o, break_o, busy_o;

  uart_rx_frame #(.DATA_BITS(8), .MIN_CPB(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rx_i           (rx_i),
    .en_i           (en_i),
    .clks_per_bit_i (clks_per_bit_i),
    .parity_en_i    (parity_en_i),
    .parity_odd_i   (parity_odd_i),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .parity_err_o   (parity_err_o),
    .frame_err_o    (frame_err_o),
    .break_o        (break_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int   vcyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input logic br);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.brk = br;
    sb.push_back(e);
  endtask

  // Scoreboard: every rx_valid_o pulse pops one expected frame.
  always @(negedge clk_i) begin
    if (rx_valid_o === 1'b1) begin
      exp_t e;
      vcyc.push_back(cyc);
      check("pulse_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rx_data", rx_data_o, e.data);
        check("parity_err", parity_err_o, e.perr);
        check("frame_err", frame_err_o, e.ferr);
        check("break", break_o, e.brk);
      end
    end
  end

  // Caller must be at posedge+1; returns at posedge+1 right after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic stop, input int nb, output int t0);
    t0 = cyc;
    rx_i = 1'b0;
    repeat (nb) @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (nb) @(posedge clk_i);
      #1;
    end
    if (has_par) begin
      rx_i = pbit;
      repeat (nb) @(posedge clk_i);
      #1;
    end
    rx_i = stop;
    repeat (nb) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_pulses(input int n, input string tag);
    int b = 0;
    while (vcyc.size() < n && b < 400) begin
      @(posedge clk_i);
      b++;
    end
    @(negedge clk_i);
    check(tag, vcyc.size(), n);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int t0, t1, bc;

  initial begin
    rst_i = 1'b1; en_i = 1'b1; rx_i = 1'b1;
    clks_per_bit_i = 16'd16; parity_en_i = 1'b0; parity_odd_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_valid", rx_valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_data", rx_data_o, 0);
    check("reset_perr", parity_err_o, 0);
    check("reset_ferr", frame_err_o, 0);
    check("reset_break", break_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    idle(5);

    // Plain 0xA5, latency from the start edge.
    push_exp(8'hA5, 0, 0, 0);
    send_frame(8'hA5, 0, 0, 1, 16, t0);
    wait_pulses(1, "a5_pulse_count");
    check("a5_latency", vcyc[0], t0 + 157);
    idle(4);

    // Odd parity, good then bad parity bit.
    parity_en_i = 1'b1; parity_odd_i = 1'b1;
    push_exp(8'h3C, 0, 0, 0);
    send_frame(8'h3C, 1, 1, 1, 16, t0);
    wait_pulses(2, "par_good_count");
    check("par_latency", vcyc[1], t0 + 173);
    push_exp(8'h3C, 1, 0, 0);
    send_frame(8'h3C, 1, 0, 1, 16, t0);
    wait_pulses(3, "par_bad_count");
    parity_en_i = 1'b0;
    idle(4);

    // Break: line low for 12 bit times.
    push_exp(8'h00, 0, 1, 1);
    rx_i = 1'b0;
    repeat (12 * 16) @(posedge clk_i);
    @(negedge clk_i);
    check("break_pulse_count", vcyc.size(), 4);
    check("break_wait_busy", busy_o, 1);
    @(posedge clk_i);
    #1 rx_i = 1'b1;
    idle(5);
    check("break_release_busy", busy_o, 0);
    idle(3);
    push_exp(8'h55, 0, 0, 0);
    send_frame(8'h55, 0, 0, 1, 16, t0);
    wait_pulses(5, "after_break_count");
    idle(4);

    // 4-cycle glitch.
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rx_i = 1'b1;
    check("glitch_busy_start", busy_o, 1);
    idle(10);
    check("glitch_busy_cleared", busy_o, 0);
    idle(10);
    check("glitch_no_pulse", vcyc.size(), 5);

    // Back-to-back frames.
    push_exp(8'h01, 0, 0, 0);
    push_exp(8'hFF, 0, 0, 0);
    send_frame(8'h01, 0, 0, 1, 16, t0);
    send_frame(8'hFF, 0, 0, 1, 16, t1);
    wait_pulses(7, "b2b_count");
    check("b2b_first_latency", vcyc[5], t0 + 157);
    check("b2b_spacing", vcyc[6] - vcyc[5], 160);
    idle(4);

    // Enable dropped mid-DATA.
    fork
      send_frame(8'h81, 0, 0, 1, 16, t0);
      begin
        idle(3 * 16 + 5);
        check("en_drop_busy_before", busy_o, 1);
        en_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("en_drop_busy_after", busy_o, 0);
      end
    join
    en_i = 1'b1;
    idle(4);
    check("en_drop_no_pulse", vcyc.size(), 7);

    // Reset mid-frame (during a high data bit).
    fork
      send_frame(8'h81, 0, 0, 1, 16, t0);
      begin
        idle(8 * 16 + 5);
        check("rst_busy_before", busy_o, 1);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        check("rst_busy_after", busy_o, 0);
      end
    join
    idle(4);
    check("rst_no_pulse", vcyc.size(), 7);
    push_exp(8'h7E, 0, 0, 0);
    send_frame(8'h7E, 0, 0, 1, 16, t0);
    wait_pulses(8, "after_rst_count");
    idle(4);

    // clks_per_bit below the floor: all traffic ignored.
    clks_per_bit_i = 16'd3;
    bc = 0;
    fork
      begin
        send_frame(8'h5A, 0, 0, 1, 3, t0);
        send_frame(8'h00, 0, 0, 1, 16, t1);
      end
      begin
        repeat (3 * 10 + 16 * 10 + 10) begin
          @(negedge clk_i);
          if (busy_o) bc++;
        end
      end
    join
    check("low_cpb_busy_cycles", bc, 0);
    clks_per_bit_i = 16'd16;
    idle(20);
    check("low_cpb_no_pulse", vcyc.size(), 8);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
